// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall controller for a five-stage in-order pipeline. It combines
// three sources of pipeline control into one set of enables and flushes:
//   - data-memory wait states (freeze of the whole pipe while MEM is busy),
//     with a timeout that parks the controller in an absorbing error state
//   - taken branches resolved in EX (flush the two younger instructions)
//   - load-use hazards (hold PC and IF/ID for one cycle, bubble into EX)
//
// All control outputs are combinational from the current state and inputs,
// so the pipeline reacts in the same cycle the condition is seen. The two
// performance counters are registered and saturate.
//
// Parameters
//   TIMEOUT          MEMWAIT cycles allowed before a memory timeout (2..255)
//
// Ports
//   clk              single clock, rising edge
//   rst_n            synchronous active-low reset
//   IF_ID_rs1/rs2    source registers of the instruction in ID
//   ID_EX_rd         destination register of the instruction in EX
//   ID_EX_MemRead    instruction in EX is a load
//   EX_branch_taken  branch/jump resolved taken in EX this cycle
//   mem_req          MEM stage is issuing a data-memory access
//   mem_ready        data memory completes the access this cycle
//   pc_write         PC load enable
//   IF_ID_write      IF/ID register load enable
//   IF_ID_flush      bubble into IF/ID
//   ID_EX_flush      bubble into ID/EX
//   EX_MEM_hold      freeze EX/MEM and MEM/WB
//   mem_err          memory-timeout flag, held until reset
//   stall_count      cycles with pc_write=0, saturating
//   flush_count      cycles with a branch flush, saturating
//
// State table
//   state   | meaning
//   RUN     | normal flow; branch and load-use rules apply
//   MEMWAIT | data access outstanding; pipe frozen until mem_ready
//   ERR     | memory timed out; pipe frozen, mem_err=1, left only by reset
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_rs1,
    input  logic [4:0]  IF_ID_rs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_MemRead,
    input  logic        EX_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        EX_MEM_hold,
    output logic        mem_err,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    // Last wait_cnt value that is still tolerated in MEMWAIT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    logic freeze;
    logic load_use;
    logic branch_flush;

    // Freeze covers both the first cycle of a missed access (still in RUN)
    // and every MEMWAIT cycle without ready. A MEMWAIT cycle with ready
    // falls through to the RUN rules.
    assign freeze = ((state == RUN) && mem_req && !mem_ready) ||
                    ((state == MEMWAIT) && !mem_ready);

    // x0 never carries a value, so a load into x0 cannot create a hazard.
    assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    assign branch_flush = rst_n && (state != ERR) && !freeze && EX_branch_taken;

    always_comb begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        EX_MEM_hold = 1'b0;
        mem_err     = 1'b0;

        if (!rst_n) begin
            // Hold fetch and keep bubbles in the front end while in reset.
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (state == ERR) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            EX_MEM_hold = 1'b1;
            mem_err     = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            EX_MEM_hold = 1'b1;
        end else if (EX_branch_taken) begin
            // The flushed instruction in ID is wrong-path, so any load-use
            // hazard it shows is irrelevant.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            // Single-cycle bubble: the bubble itself clears ID_EX_MemRead
            // next cycle, so nothing needs to be remembered here.
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= MEMWAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MEMWAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            if (!pc_write && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end

            if (branch_flush && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=4. Inputs change 1ns
// after the rising edge; outputs are sampled on the falling edge. Control
// outputs are compared as one packed vector:
//   {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold, mem_err}
// Counter expectations are kept in exp_stall / exp_flush and advanced by
// the known per-cycle behaviour of each scenario.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic [4:0]  ID_EX_rd;
    logic        ID_EX_MemRead;
    logic        EX_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_write;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        EX_MEM_hold;
    logic        mem_err;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    logic [5:0]  outs;
    int          n_vec;
    int          n_err;
    int          exp_stall;
    int          exp_flush;

    localparam logic [5:0] O_DEF    = 6'b110000;
    localparam logic [5:0] O_RST    = 6'b001100;
    localparam logic [5:0] O_LU     = 6'b000100;
    localparam logic [5:0] O_BR     = 6'b111100;
    localparam logic [5:0] O_FREEZE = 6'b000010;
    localparam logic [5:0] O_ERR    = 6'b000011;

    assign outs = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_hold, mem_err};

    pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2),
        .ID_EX_rd        (ID_EX_rd),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .EX_branch_taken (EX_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .IF_ID_write     (IF_ID_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .EX_MEM_hold     (EX_MEM_hold),
        .mem_err         (mem_err),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IF_ID_rs1       = 5'd0;
        IF_ID_rs2       = 5'd0;
        ID_EX_rd        = 5'd0;
        ID_EX_MemRead   = 1'b0;
        EX_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        next_cycle();
        @(negedge clk);
        n_vec++; if (outs !== O_RST) begin n_err++; $display("FAIL reset_outs outs=%b want %b", outs, O_RST); end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL reset_release_outs outs=%b want %b", outs, O_DEF); end
        n_vec++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
        n_vec++; if (flush_count !== 16'd0) begin n_err++; $display("FAIL reset_flush_count got %0d want 0", flush_count); end
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_load_use();
        // rs2 match
        next_cycle();
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd3; IF_ID_rs2 = 5'd5;
        @(negedge clk);
        n_vec++; if (outs !== O_LU) begin n_err++; $display("FAIL load_use_rs2 outs=%b want %b", outs, O_LU); end
        exp_stall += 1;
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL load_use_after outs=%b want %b", outs, O_DEF); end
        n_vec++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL load_use_stall_count got %0d want %0d", stall_count, exp_stall); end
        // rs1 match
        next_cycle();
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd7; IF_ID_rs1 = 5'd7; IF_ID_rs2 = 5'd9;
        @(negedge clk);
        n_vec++; if (outs !== O_LU) begin n_err++; $display("FAIL load_use_rs1 outs=%b want %b", outs, O_LU); end
        exp_stall += 1;
        // no register match
        next_cycle();
        IF_ID_rs1 = 5'd6; IF_ID_rs2 = 5'd8;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL load_use_nomatch outs=%b want %b", outs, O_DEF); end
        // match but not a load
        next_cycle();
        ID_EX_MemRead = 1'b0; IF_ID_rs1 = 5'd7;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL load_use_notload outs=%b want %b", outs, O_DEF); end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL load_use_stall_total got %0d want %0d", stall_count, exp_stall); end
    endtask

    task automatic test_rd_zero();
        next_cycle();
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL rd_zero outs=%b want %b", outs, O_DEF); end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL rd_zero_stall_count got %0d want %0d", stall_count, exp_stall); end
    endtask

    task automatic test_branch();
        next_cycle();
        EX_branch_taken = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; IF_ID_rs2 = 5'd5;
        @(negedge clk);
        n_vec++; if (outs !== O_BR) begin n_err++; $display("FAIL branch_load_use outs=%b want %b", outs, O_BR); end
        exp_flush += 1;
        next_cycle();
        idle();
        EX_branch_taken = 1'b1;
        @(negedge clk);
        n_vec++; if (outs !== O_BR) begin n_err++; $display("FAIL branch_plain outs=%b want %b", outs, O_BR); end
        n_vec++; if (flush_count !== 16'(exp_flush)) begin n_err++; $display("FAIL branch_flush_count1 got %0d want %0d", flush_count, exp_flush); end
        n_vec++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL branch_stall_unchanged got %0d want %0d", stall_count, exp_stall); end
        exp_flush += 1;
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if (flush_count !== 16'(exp_flush)) begin n_err++; $display("FAIL branch_flush_count2 got %0d want %0d", flush_count, exp_flush); end
    endtask

    task automatic test_mem_wait();
        // First missed cycle also carries a taken branch: freeze wins.
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0; EX_branch_taken = 1'b1;
        @(negedge clk);
        n_vec++; if (outs !== O_FREEZE) begin n_err++; $display("FAIL mem_wait_c0 outs=%b want %b", outs, O_FREEZE); end
        exp_stall += 1;
        for (int i = 1; i < 3; i++) begin
            next_cycle();
            EX_branch_taken = 1'b0;
            @(negedge clk);
            n_vec++; if (outs !== O_FREEZE) begin n_err++; $display("FAIL mem_wait_c%0d outs=%b want %b", i, outs, O_FREEZE); end
            exp_stall += 1;
        end
        next_cycle();
        mem_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL mem_wait_ready outs=%b want %b", outs, O_DEF); end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL mem_wait_back_to_run outs=%b want %b", outs, O_DEF); end
        n_vec++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL mem_wait_stall_count got %0d want %0d", stall_count, exp_stall); end
        n_vec++; if (flush_count !== 16'(exp_flush)) begin n_err++; $display("FAIL mem_wait_flush_count got %0d want %0d", flush_count, exp_flush); end
    endtask

    task automatic test_mem_hit();
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL mem_hit outs=%b want %b", outs, O_DEF); end
        next_cycle();
        mem_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL mem_ready_noreq outs=%b want %b", outs, O_DEF); end
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL mem_noreq_stays_run outs=%b want %b", outs, O_DEF); end
        n_vec++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL mem_hit_stall_count got %0d want %0d", stall_count, exp_stall); end
    endtask

    task automatic test_back_to_back();
        // MEMWAIT exit cycle applies RUN rules at once: load-use shows up.
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (outs !== O_FREEZE) begin n_err++; $display("FAIL b2b_freeze outs=%b want %b", outs, O_FREEZE); end
        exp_stall += 1;
        next_cycle();
        mem_ready = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd12; IF_ID_rs1 = 5'd12;
        @(negedge clk);
        n_vec++; if (outs !== O_LU) begin n_err++; $display("FAIL b2b_exit_load_use outs=%b want %b", outs, O_LU); end
        exp_stall += 1;
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL b2b_after outs=%b want %b", outs, O_DEF); end
        n_vec++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL b2b_stall_count got %0d want %0d", stall_count, exp_stall); end
    endtask

    task automatic test_timeout();
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (outs !== O_FREEZE) begin n_err++; $display("FAIL timeout_c%0d outs=%b want %b", i, outs, O_FREEZE); end
            exp_stall += 1;
            next_cycle();
        end
        @(negedge clk);
        n_vec++; if (outs !== O_ERR) begin n_err++; $display("FAIL timeout_c5_err outs=%b want %b", outs, O_ERR); end
        n_vec++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL timeout_stall_count got %0d want %0d", stall_count, exp_stall); end
        // ERR absorbs: ready, branch and load-use are all ignored.
        next_cycle();
        mem_req = 1'b0; mem_ready = 1'b1; EX_branch_taken = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd4; IF_ID_rs1 = 5'd4;
        @(negedge clk);
        n_vec++; if (outs !== O_ERR) begin n_err++; $display("FAIL timeout_absorb outs=%b want %b", outs, O_ERR); end
        next_cycle();
        idle();
        @(negedge clk);
        n_vec++; if (flush_count !== 16'(exp_flush)) begin n_err++; $display("FAIL timeout_no_flush got %0d want %0d", flush_count, exp_flush); end
    endtask

    task automatic test_saturation();
        // Still in ERR: every edge stalls.
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++; if (stall_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_stall_count got %h want ffff", stall_count); end
        n_vec++; if (outs !== O_ERR) begin n_err++; $display("FAIL sat_still_err outs=%b want %b", outs, O_ERR); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (stall_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want ffff", stall_count); end
    endtask

    task automatic test_reset_recovery();
        // Reset out of ERR.
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (outs !== O_RST) begin n_err++; $display("FAIL err_reset_outs outs=%b want %b", outs, O_RST); end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL err_reset_run outs=%b want %b", outs, O_DEF); end
        n_vec++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL err_reset_stall got %0d want 0", stall_count); end
        n_vec++; if (flush_count !== 16'd0) begin n_err++; $display("FAIL err_reset_flush got %0d want 0", flush_count); end
        // Reset out of MEMWAIT.
        next_cycle();
        mem_req = 1'b1; mem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        n_vec++; if (outs !== O_FREEZE) begin n_err++; $display("FAIL mw_reset_inwait outs=%b want %b", outs, O_FREEZE); end
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (outs !== O_RST) begin n_err++; $display("FAIL mw_reset_outs outs=%b want %b", outs, O_RST); end
        next_cycle();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        n_vec++; if (outs !== O_DEF) begin n_err++; $display("FAIL mw_reset_no_freeze outs=%b want %b", outs, O_DEF); end
        n_vec++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL mw_reset_stall got %0d want 0", stall_count); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_stall = 0;
        exp_flush = 0;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch();
        test_mem_wait();
        test_mem_hit();
        test_back_to_back();
        test_timeout();
        test_saturation();
        test_reset_recovery();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255 (range 2..255): MEMWAIT cycles allowed before a memory-timeout error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 IF_ID_rs1, IF_ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 ID_EX_rd  input  5  destination register of the instruction in EX.
REQ-006 ID_EX_MemRead  input  1  the instruction in EX is a load.
REQ-007 EX_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-008 mem_req  input  1  MEM stage is issuing a data-memory access.
REQ-009 mem_ready  input  1  data memory completes the access this cycle.
REQ-010 pc_write  output  1  PC load enable.
REQ-011 IF_ID_write  output  1  IF/ID register load enable.
REQ-012 IF_ID_flush, ID_EX_flush  output  1 each  insert a bubble into IF/ID or ID/EX.
REQ-013 EX_MEM_hold  output  1  freeze EX/MEM and MEM/WB.
REQ-014 mem_err  output  1  sticky memory-timeout flag.
REQ-015 stall_count  output  16  cycles with pc_write=0; saturating.
REQ-016 flush_count  output  16  cycles with a branch flush; saturating.

Function
REQ-017 The FSM SHALL have three states: RUN, MEMWAIT and ERR, plus a wait counter wait_cnt[7:0].
REQ-018 Outputs SHALL be combinational (Mealy) from state and inputs; the defaults are pc_write=1, IF_ID_write=1, and flushes, EX_MEM_hold and mem_err all 0.
REQ-019 Priority SHALL be: ERR, then memory freeze, then branch flush, then load-use.
REQ-020 Memory freeze (RUN with mem_req=1 and mem_ready=0, or MEMWAIT with mem_ready=0) SHALL drive pc_write=0, IF_ID_write=0 and EX_MEM_hold=1, with no flushes.
REQ-021 In RUN, mem_req=1 with mem_ready=0 SHALL set next state to MEMWAIT and wait_cnt to 0.
REQ-022 In MEMWAIT with mem_ready=0: if wait_cnt==TIMEOUT-1, the next state SHALL be ERR; otherwise wait_cnt SHALL increment.
REQ-023 In MEMWAIT with mem_ready=1, outputs SHALL follow the RUN rules (REQ-024..026) in the same cycle, and the next state SHALL be RUN.
REQ-024 Branch flush: EX_branch_taken=1 with no freeze SHALL drive IF_ID_flush=1, ID_EX_flush=1, pc_write=1 and IF_ID_write=1, and SHALL suppress load-use.
REQ-025 Load-use: ID_EX_MemRead=1, ID_EX_rd!=0, and ID_EX_rd equal to IF_ID_rs1 or IF_ID_rs2 SHALL drive pc_write=0, IF_ID_write=0 and ID_EX_flush=1 for exactly that cycle; it is not registered.
REQ-026 A load-use bubble SHALL NOT retrigger, because the bubble clears ID_EX_MemRead on the next cycle; no extra state is needed.
REQ-027 ERR SHALL be absorbing until reset and SHALL drive mem_err=1, pc_write=0, IF_ID_write=0, EX_MEM_hold=1 and no flushes.
REQ-028 stall_count SHALL increment on each clock edge where pc_write=0 and rst_n=1, saturating at 16'hFFFF.
REQ-029 flush_count SHALL increment on each edge where the branch flush of REQ-024 is active, saturating at 16'hFFFF.
REQ-030 mem_req=1 with mem_ready=1 in RUN SHALL cause no stall.
REQ-031 mem_ready in RUN with mem_req=0 SHALL be ignored.

Reset
REQ-032 On a clock edge with rst_n=0: state SHALL become RUN, and wait_cnt, stall_count, flush_count and mem_err SHALL become 0.
REQ-033 While rst_n=0, outputs SHALL be forced to pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1 and EX_MEM_hold=0.
REQ-034 Reset asserted in MEMWAIT or ERR SHALL return the FSM to RUN on that edge, with no residual freeze.

Verification
REQ-035 Load-use: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5 for 1 cycle -> that cycle pc_write=0, IF_ID_write=0, ID_EX_flush=1; stall_count=1 afterwards.
REQ-036 Branch plus load-use: EX_branch_taken=1 with the REQ-035 hazard -> IF_ID_flush=1, ID_EX_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
REQ-037 rd=x0: ID_EX_MemRead=1, ID_EX_rd=0, IF_ID_rs1=0 -> no stall, all outputs at default.
REQ-038 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> EX_MEM_hold=1 for 3 cycles; RUN after the ready cycle; stall_count=3.
REQ-039 Timeout, TIMEOUT=4: mem_req=1, mem_ready held 0 -> cycle 0 RUN, cycles 1..4 MEMWAIT, ERR and mem_err=1 from cycle 5 until rst_n=0.
REQ-040 Saturation and reset: force 70000 stall cycles -> stall_count=16'hFFFF; rst_n=0 for one edge -> all counters 0, state RUN.
